// File: rtl/pipe_credit_rx.sv
// Generic synchronous show-ahead FIFO: head entry is always visible on rdata.
// Latency: a write is visible on rdata/count one cycle later; no write-to-read bypass.
// Backpressure: none internally; caller must gate push when full (push with pop on full is legal).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two; count tracks net push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage is not reset: contents are only observed once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// Receive-end buffer for a credit-managed pipe: captures every valid beat, serves it downstream.
// Latency: beat captured in cycle N appears on out_valid/out_data in N+1; credit one cycle after pop.
// Backpressure: out_ready stalls the head beat; the pipe side cannot stall, so a beat into a full buffer is dropped and flagged.
module pipe_credit_rx #(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 8,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             credit_return,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic pop;
  logic push;
  logic full;
  logic empty;

  // A full buffer can still take a beat when the head leaves in the same cycle.
  assign pop       = out_valid & out_ready;
  assign push      = valid_in & (!full | pop);
  assign out_valid = !empty;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (data_in),
    .pop   (pop),
    .rdata (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // One credit per consumed beat, a cycle late; dropped beats never earn a credit.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_return <= 1'b0;
    end else begin
      credit_return <= pop;
    end
  end

  // Sticky drop indicator: the sender exceeded its credit budget at least once since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (valid_in && full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_credit_rx.sv
module tb_pipe_credit_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       credit_return;
  logic [3:0] count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state: scoreboard of accepted beats plus expected registered flags.
  logic [7:0] exp_q[$];
  logic       exp_cred = 1'b0;
  logic       exp_ovf  = 1'b0;

  always #5 clk = ~clk;

  pipe_credit_rx #(
    .WIDTH     (8),
    .BUF_DEPTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .credit_return (credit_return),
    .count         (count),
    .overflow      (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, compare outputs against the model,
  // then advance the model to what the DUT should hold after the next posedge.
  task automatic step(input logic rst, input logic v, input logic [7:0] d, input logic rdy);
    bit m_pop;
    bit m_full;
    bit m_push;
    @(negedge clk);
    reset     = rst;
    valid_in  = v;
    data_in   = d;
    out_ready = rdy;
    #1;
    chk("count", count, exp_q.size());
    chk("out_valid", out_valid, (exp_q.size() != 0));
    if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
    chk("credit_return", credit_return, exp_cred);
    chk("overflow", overflow, exp_ovf);
    if (rst) begin
      exp_q.delete();
      exp_cred = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      m_pop  = (exp_q.size() != 0) && rdy;
      m_full = (exp_q.size() == 8);
      m_push = v && (!m_full || m_pop);
      if (v && m_full && !m_pop) exp_ovf = 1'b1;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(d);
      exp_cred = m_pop;
    end
    @(posedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    valid_in  = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);

    // Reset state check, then three beats with the consumer stalled.
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h22, 0);
    step(0, 1, 8'h33, 0);
    #2;
    chk("fill3_count", count, 3);
    chk("fill3_head", out_data, 8'h11);
    chk("fill3_no_credit", credit_return, 1'b0);

    // Drain three beats in order; credits trail each pop by one cycle.
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    #2;
    chk("drain3_count", count, 0);
    chk("drain3_valid", out_valid, 1'b0);
    chk("drain3_last_credit", credit_return, 1'b1);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // Fill to capacity, then push and pop together on the full buffer.
    for (int i = 0; i < 8; i++) step(0, 1, 8'(i), 0);
    step(0, 1, 8'hAA, 1);
    #2;
    chk("fullpp_count", count, 8);
    chk("fullpp_ovf", overflow, 1'b0);
    chk("fullpp_head", out_data, 8'h01);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Fill to capacity, then a beat with no pop must be dropped and flagged.
    for (int i = 0; i < 8; i++) step(0, 1, 8'h80 + 8'(i), 0);
    step(0, 1, 8'h55, 0);
    #2;
    chk("drop_ovf", overflow, 1'b1);
    chk("drop_count", count, 8);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    #2;
    chk("drop_ovf_sticky", overflow, 1'b1);
    chk("drop_empty", out_valid, 1'b0);

    // Streaming: one in, one out every cycle, occupancy parked at one.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 8'h40 + 8'(i), 1);
      if (i == 0) begin
        #2;
        chk("stream_count_first", count, 1);
      end
    end
    #2;
    chk("stream_count_end", count, 1);
    chk("stream_credit", credit_return, 1'b1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Reset mid-stream discards buffered beats and clears overflow and credit.
    for (int i = 0; i < 5; i++) step(0, 1, 8'hC0 + 8'(i), 0);
    step(1, 1, 8'hEE, 1);
    #2;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_credit", credit_return, 1'b0);
    step(0, 1, 8'h77, 0);
    #2;
    chk("post_rst_head", out_data, 8'h77);
    chk("post_rst_count", count, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
